// File: rtl/mac_neuron.sv
// -----------------------------------------------------------------------------
// mac_neuron
//
// Fixed-point perceptron: out = act((bias << FRAC_BITS + sum(x[i]*w[i])) >>> FRAC_BITS)
// Each accepted input vector is processed over BEATS = NUM_INPUTS/NUM_LANES
// MAC cycles, using NUM_LANES multipliers per cycle. This is followed by one
// activation cycle. The result is then held until downstream takes it.
// Weights and the bias can be written at runtime, but only while idle.
//
// Parameters
//   DATA_WIDTH  width of signed inputs, weights, bias and output
//   FRAC_BITS   fractional bits of the fixed-point format (0 = integer)
//   NUM_INPUTS  inputs per neuron (multiple of NUM_LANES)
//   NUM_LANES   multipliers used per MAC cycle
//   ACTIVATION  0 = identity, 1 = ReLU, 2 = leaky ReLU (negative slope 1/8)
//
// Ports
//   clock, reset_n        clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input vector handshake; in_ready is high only in IDLE
//   inputs                signed input vector (unpacked array)
//   w_we/w_addr/w_data    weight write; w_addr == NUM_INPUTS selects the bias
//   out / out_valid       registered, activated result and its valid flag
//   out_ready             downstream accepts out
//
// Build option
//   MAC_NEURON_SATURATE_EN  when defined, narrowing to DATA_WIDTH saturates;
//                           otherwise the low DATA_WIDTH bits are kept (wrap).
// -----------------------------------------------------------------------------
module mac_neuron #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int NUM_INPUTS = 16,
  parameter int NUM_LANES  = 4,
  parameter int ACTIVATION = 1
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [DATA_WIDTH-1:0]          inputs [NUM_INPUTS],
  input  logic                                  w_we,
  input  logic [$clog2(NUM_INPUTS+1)-1:0]       w_addr,
  input  logic signed [DATA_WIDTH-1:0]          w_data,
  output logic signed [DATA_WIDTH-1:0]          out,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  localparam int BEATS  = NUM_INPUTS / NUM_LANES;
  localparam int ACC_W  = 2 * DATA_WIDTH + $clog2(NUM_INPUTS) + 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ADDR_W = $clog2(NUM_INPUTS + 1);
  localparam int IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_ACT,
    ST_DONE
  } state_t;

  state_t                        state_q;
  logic signed [DATA_WIDTH-1:0]  x_q [NUM_INPUTS];   // input snapshot
  logic signed [DATA_WIDTH-1:0]  w_q [NUM_INPUTS];   // weights
  logic signed [DATA_WIDTH-1:0]  bias_q;
  logic signed [ACC_W-1:0]       acc_q;
  logic [BEAT_W-1:0]             beat_q;
  logic signed [DATA_WIDTH-1:0]  out_q;
  logic                          out_valid_q;

  // A weight write that coincides with an input accept must not affect that
  // vector. The old value of the written weight is kept here and is used in
  // place of the register-file entry for that one computation.
  logic                          shadow_valid_q;
  logic [IDX_W-1:0]              shadow_addr_q;
  logic signed [DATA_WIDTH-1:0]  shadow_data_q;

  logic signed [ACC_W-1:0]       lane_sum;
  logic signed [ACC_W-1:0]       shifted;
  logic signed [ACC_W-1:0]       activated;
  logic signed [DATA_WIDTH-1:0]  out_d;

  logic                          w_is_weight;
  logic                          w_is_bias;
  logic                          last_beat;

  assign w_is_weight = (w_addr <  ADDR_W'(NUM_INPUTS));
  assign w_is_bias   = (w_addr == ADDR_W'(NUM_INPUTS));
  assign last_beat   = (beat_q == BEAT_W'(BEATS - 1));

  // Sum of this beat's NUM_LANES full-width signed products.
  always_comb begin
    logic [IDX_W-1:0]             idx;
    logic signed [DATA_WIDTH-1:0] w_eff;
    logic signed [PROD_W-1:0]     prod;
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    lane_sum = '0;
    idx      = '0;
    w_eff    = '0;
    prod     = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      idx   = IDX_W'(beat_q) * IDX_W'(NUM_LANES) + IDX_W'(l);
      w_eff = w_q[idx];
      if (shadow_valid_q && (shadow_addr_q == idx)) begin
        w_eff = shadow_data_q;
      end
      prod     = PROD_W'(x_q[idx]) * PROD_W'(w_eff);
      lane_sum = lane_sum + ACC_W'(prod);
    end
  end

  // Rescale, activate and narrow the finished accumulator.
  always_comb begin
    shifted   = acc_q >>> FRAC_BITS;
    activated = shifted;
    if (ACTIVATION == 1) begin
      activated = shifted[ACC_W-1] ? '0 : shifted;
    end else if (ACTIVATION == 2) begin
      activated = shifted[ACC_W-1] ? (shifted >>> 3) : shifted;
    end
`ifdef MAC_NEURON_SATURATE_EN
    if (activated > $signed({{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}})) begin
      out_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (activated < $signed({{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}})) begin
      out_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      out_d = DATA_WIDTH'(activated);
    end
`else
    out_d = DATA_WIDTH'(activated);
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the weight and input arrays are small flop banks, not RAM, and reset must leave the weights cleared, so they are reset here.
      state_q        <= ST_IDLE;
      x_q            <= '{default: '0};
      w_q            <= '{default: '0};
      bias_q         <= '0;
      acc_q          <= '0;
      beat_q         <= '0;
      out_q          <= '0;
      out_valid_q    <= 1'b0;
      shadow_valid_q <= 1'b0;
      shadow_addr_q  <= '0;
      shadow_data_q  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so every register sees pre-edge values.
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            x_q            <= inputs;
            acc_q          <= ACC_W'(bias_q) <<< FRAC_BITS;
            beat_q         <= '0;
            shadow_valid_q <= w_we && w_is_weight;
            shadow_addr_q  <= IDX_W'(w_addr);
            shadow_data_q  <= w_q[IDX_W'(w_addr)];
            state_q        <= ST_MAC;
          end
          if (w_we) begin
            if (w_is_weight) begin
              w_q[IDX_W'(w_addr)] <= w_data;
            end else if (w_is_bias) begin
              bias_q <= w_data;
            end
          end
        end
        ST_MAC: begin
          acc_q  <= acc_q + lane_sum;
          beat_q <= beat_q + BEAT_W'(1);
          if (last_beat) begin
            state_q <= ST_ACT;
          end
        end
        ST_ACT: begin
          out_q       <= out_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_neuron.sv
// -----------------------------------------------------------------------------
// tb_mac_neuron
//
// Three mac_neuron instances with different configurations share one stimulus
// stream. Instance 0 uses FRAC_BITS=0, 2 lanes and ReLU. Instance 1 uses
// FRAC_BITS=8, 4 lanes and leaky ReLU. Instance 2 uses FRAC_BITS=0, 1 lane and
// identity. Each instance has 4 inputs.
// A transaction-level model per instance predicts in_ready, out_valid and out
// every cycle. The model computes results with plain longint arithmetic and
// tracks timing as a cycle count from the accepting edge.
// Directed sequences pin the model with hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mac_neuron;

  localparam int DW   = 16;
  localparam int NI   = 4;
  localparam int AW   = 3;
  localparam int NDUT = 3;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 w_we = 1'b0;
  logic                 out_ready = 1'b0;
  logic [AW-1:0]        w_addr = '0;
  logic signed [DW-1:0] w_data = '0;
  logic signed [DW-1:0] inputs [NI];

  logic                 in_ready_k  [NDUT];
  logic                 out_valid_k [NDUT];
  logic signed [DW-1:0] out_k       [NDUT];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  mac_neuron #(.DATA_WIDTH(DW), .FRAC_BITS(0), .NUM_INPUTS(NI), .NUM_LANES(2), .ACTIVATION(1)) u_a (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_k[0]),
    .inputs(inputs), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out(out_k[0]), .out_valid(out_valid_k[0]), .out_ready(out_ready));

  mac_neuron #(.DATA_WIDTH(DW), .FRAC_BITS(8), .NUM_INPUTS(NI), .NUM_LANES(4), .ACTIVATION(2)) u_b (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_k[1]),
    .inputs(inputs), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out(out_k[1]), .out_valid(out_valid_k[1]), .out_ready(out_ready));

  mac_neuron #(.DATA_WIDTH(DW), .FRAC_BITS(0), .NUM_INPUTS(NI), .NUM_LANES(1), .ACTIVATION(0)) u_c (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_k[2]),
    .inputs(inputs), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out(out_k[2]), .out_valid(out_valid_k[2]), .out_ready(out_ready));

  // ---------------- behavioural model ----------------
  logic signed [DW-1:0] m_w    [NDUT][NI];
  logic signed [DW-1:0] m_b    [NDUT];
  logic signed [DW-1:0] m_out  [NDUT];
  logic signed [DW-1:0] m_pend [NDUT];
  bit                   m_ready [NDUT];
  bit                   m_valid [NDUT];
  int                   m_cnt   [NDUT];

  function automatic int frac_of(input int k);
    return (k == 1) ? 8 : 0;
  endfunction

  function automatic int beats_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int act_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 0;
    endcase
  endfunction

  // Result for the current input vector with instance k's current weights.
  function automatic logic signed [DW-1:0] model_result(input int k);
    longint sum;
    longint r;
    sum = longint'(m_b[k]) * (longint'(1) << frac_of(k));
    for (int i = 0; i < NI; i++) begin
      sum = sum + longint'(inputs[i]) * longint'(m_w[k][i]);
    end
    r = sum >>> frac_of(k);
    if (act_of(k) == 1 && r < 0) r = 0;
    if (act_of(k) == 2 && r < 0) r = r >>> 3;
`ifdef MAC_NEURON_SATURATE_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[DW-1:0];
  endfunction

  // Advance every model by one rising edge, using the inputs held across it.
  task automatic model_step();
    bit idle;
    for (int k = 0; k < NDUT; k++) begin
      if (!reset_n) begin
        m_ready[k] = 1'b1;
        m_valid[k] = 1'b0;
        m_cnt[k]   = 0;
        m_out[k]   = '0;
        m_pend[k]  = '0;
        m_b[k]     = '0;
        for (int i = 0; i < NI; i++) m_w[k][i] = '0;
      end else begin
        idle = m_ready[k];
        if (m_ready[k] && in_valid) begin
          m_pend[k]  = model_result(k);
          m_cnt[k]   = beats_of(k) + 1;
          m_ready[k] = 1'b0;
        end else if (m_cnt[k] > 0) begin
          m_cnt[k] = m_cnt[k] - 1;
          if (m_cnt[k] == 0) begin
            m_valid[k] = 1'b1;
            m_out[k]   = m_pend[k];
          end
        end else if (m_valid[k] && out_ready) begin
          m_valid[k] = 1'b0;
          m_ready[k] = 1'b1;
        end
        if (idle && w_we) begin
          if (int'(w_addr) < NI) m_w[k][int'(w_addr)] = w_data;
          else if (int'(w_addr) == NI) m_b[k] = w_data;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("in_ready[%0d]", k),  16'(in_ready_k[k]),  16'(m_ready[k]));
      check($sformatf("out_valid[%0d]", k), 16'(out_valid_k[k]), 16'(m_valid[k]));
      check($sformatf("out[%0d]", k),       out_k[k],            m_out[k]);
    end
  endtask

  // One clock cycle: model follows the rising edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic write_w(input int addr, input int data);
    w_we   = 1'b1;
    w_addr = AW'(addr);
    w_data = DW'(data);
    tick();
    w_we   = 1'b0;
  endtask

  task automatic load_all(input int w0, input int w1, input int w2, input int w3, input int b);
    write_w(0, w0);
    write_w(1, w1);
    write_w(2, w2);
    write_w(3, w3);
    write_w(4, b);
  endtask

  task automatic set_inputs(input int v);
    for (int i = 0; i < NI; i++) inputs[i] = DW'(v);
  endtask

  // Accept one vector in all instances and wait until every instance holds its result.
  task automatic send_and_hold();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    repeat (6) tick();
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int v;
    set_inputs(0);
    repeat (2) tick();
    check("reset out", out_k[0], 16'h0000);
    check("reset out_valid", 16'(out_valid_k[0]), 16'h0000);
    check("reset in_ready", 16'(in_ready_k[0]), 16'h0001);
    reset_n = 1'b1;
    tick();

    // Basic MAC, with latency check on instance 0 (valid on 3rd edge after accept).
    load_all(1, 2, 3, 4, 5);
    set_inputs(1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("basic valid@1", 16'(out_valid_k[0]), 16'h0000);
    check("basic in_ready busy", 16'(in_ready_k[0]), 16'h0000);
    tick();
    check("basic valid@2", 16'(out_valid_k[0]), 16'h0000);
    tick();
    check("basic valid@3", 16'(out_valid_k[0]), 16'h0001);
    repeat (3) tick();
    check("basic relu", out_k[0], 16'h000F);
    check("basic leaky frac8", out_k[1], 16'h0005);
    check("basic identity", out_k[2], 16'h000F);
    release_out();

    // Negative sum.
    load_all(-1, -1, -1, -1, 0);
    set_inputs(2);
    send_and_hold();
    check("neg relu", out_k[0], 16'h0000);
    check("neg leaky", out_k[1], 16'hFFFF);
    check("neg identity", out_k[2], 16'hFFF8);
    release_out();

    // Overflow.
    load_all(32767, 32767, 32767, 32767, 0);
    set_inputs(32767);
    send_and_hold();
`ifdef MAC_NEURON_SATURATE_EN
    check("ovf relu", out_k[0], 16'h7FFF);
    check("ovf frac8", out_k[1], 16'h7FFF);
    check("ovf identity", out_k[2], 16'h7FFF);
`else
    check("ovf relu", out_k[0], 16'h0004);
    check("ovf frac8", out_k[1], 16'hFC00);
    check("ovf identity", out_k[2], 16'h0004);
`endif
    release_out();

    // Fixed point: 0.5 weights, bias 1.0, inputs 2.0 -> 5.0.
    load_all(16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0100);
    set_inputs(16'h0200);
    send_and_hold();
    check("fixed point", out_k[1], 16'h0500);
    release_out();

    // Backpressure and write lockout.
    load_all(1, 2, 3, 4, 5);
    set_inputs(1);
    send_and_hold();
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      set_inputs(9);
      if (c == 3) begin
        w_we   = 1'b1;
        w_addr = '0;
        w_data = 16'sd100;
      end
      tick();
      w_we = 1'b0;
      check("hold out", out_k[0], 16'h000F);
      check("hold out_valid", 16'(out_valid_k[0]), 16'h0001);
      check("hold in_ready", 16'(in_ready_k[0]), 16'h0000);
    end
    in_valid = 1'b0;
    set_inputs(1);
    release_out();
    check("release in_ready", 16'(in_ready_k[0]), 16'h0001);
    send_and_hold();
    check("dropped write", out_k[0], 16'h000F);
    release_out();

    // Write coinciding with accept: old weight used now, new weight next time.
    w_we     = 1'b1;
    w_addr   = '0;
    w_data   = 16'sd11;
    in_valid = 1'b1;
    tick();
    w_we     = 1'b0;
    in_valid = 1'b0;
    repeat (6) tick();
    check("write+accept old", out_k[0], 16'h000F);
    release_out();
    send_and_hold();
    check("write+accept new", out_k[0], 16'h0019);
    release_out();

    // Reset in the middle of MAC.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    check("midreset out", out_k[0], 16'h0000);
    check("midreset out_valid", 16'(out_valid_k[0]), 16'h0000);
    check("midreset in_ready", 16'(in_ready_k[0]), 16'h0001);
    reset_n = 1'b1;
    tick();
    send_and_hold();
    check("post-reset relu", out_k[0], 16'h0000);
    check("post-reset identity", out_k[2], 16'h0000);
    release_out();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      w_we      = ($urandom_range(0, 3) == 0);
      w_addr    = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        v = int'($urandom_range(0, 16)) - 8;
        w_data = DW'(v);
      end else begin
        w_data = DW'($urandom);
      end
      for (int i = 0; i < NI; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          v = int'($urandom_range(0, 40)) - 20;
          inputs[i] = DW'(v);
        end else begin
          inputs[i] = DW'($urandom);
        end
      end
      reset_n = !(c == 700);
      tick();
    end
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    w_we      = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
